// File: rtl/tdm_slot_sequencer_pkg.sv
// Shared definitions for the TDM slot sequencer: FSM encoding, widths and
// the timer load-value helper.
package tdm_slot_sequencer_pkg;

  localparam int CH_NUM = 4;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 8;
  localparam int TMR_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SLOT = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // A phase lasting N cycles is loaded as N-1 and ends when the count hits 0.
  function automatic logic [TMR_W-1:0] load_val(input int cycles);
    return (cycles > 0) ? TMR_W'(cycles - 1) : '0;
  endfunction

endpackage

// File: rtl/tdm_slot_sequencer_if.sv
// Frame handshake plus demux drive bundle between the upstream source
// (master) and the sequencer (slave).
interface tdm_slot_sequencer_if;
  import tdm_slot_sequencer_pkg::*;

  logic              iValid;
  logic [CH_NUM-1:0] iData;
  logic              oReady;
  logic              oC;
  logic              oS0;
  logic              oS1;
  logic              oStrobe;
  logic              oFrameDone;
  logic [CNT_W-1:0]  oFrameCnt;

  modport master (
    output iValid, iData,
    input  oReady, oC, oS0, oS1, oStrobe, oFrameDone, oFrameCnt
  );

  modport slave (
    input  iValid, iData,
    output oReady, oC, oS0, oS1, oStrobe, oFrameDone, oFrameCnt
  );

endinterface

// File: rtl/tdm_slot_sequencer_slot_timer.sv
// Shared 8-bit down-counter timing both the channel slots and the
// post-frame gap. o_tc is high while the count sits at zero.
module tdm_slot_sequencer_slot_timer
  import tdm_slot_sequencer_pkg::*;
(
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_load_val,
  output logic             o_tc
);

  logic [TMR_W-1:0] r_count;
  logic             w_tc;

  assign w_tc = (r_count == '0);
  assign o_tc = w_tc;

  // Load on phase entry, otherwise count down and park at zero.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (!w_tc) begin
      r_count <= r_count - TMR_W'(1);
    end
  end

endmodule

// File: rtl/tdm_slot_sequencer.sv
// TDM slot sequencer: accepts a 4-bit frame and walks the 1-to-4 demux
// selects through channels 0..3, presenting one frame bit per slot.
// All outputs are registered from next-state values so the first slot is
// visible the cycle after the accept.
module tdm_slot_sequencer
  import tdm_slot_sequencer_pkg::*;
#(
  parameter int HOLD = 4,
  parameter int GAP  = 1
) (
  input logic                 iClk,
  input logic                 iRst_n,
  tdm_slot_sequencer_if.slave bus
);

  if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
    $error("tdm_slot_sequencer: HOLD must be in 1..255");
  end
  if (GAP < 0 || GAP > 255) begin : g_bad_gap
    $error("tdm_slot_sequencer: GAP must be in 0..255");
  end

  localparam logic [TMR_W-1:0] HOLD_LD = load_val(HOLD);
  localparam logic [TMR_W-1:0] GAP_LD  = load_val(GAP);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CH_NUM - 1);

  state_t            r_state, w_state_nxt;
  logic [SEL_W-1:0]  r_ch, w_ch_nxt;
  logic [CH_NUM-1:0] r_frame, w_frame_nxt;

  logic              r_ready, r_c, r_strobe, r_done;
  logic [SEL_W-1:0]  r_sel;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_ready_nxt, w_c_nxt, w_strobe_nxt, w_done_nxt;
  logic [SEL_W-1:0]  w_sel_nxt;

  logic              w_accept, w_tc, w_tmr_load;
  logic [TMR_W-1:0]  w_tmr_val;

  assign w_accept = r_ready && bus.iValid;

  tdm_slot_sequencer_slot_timer u_timer (
    .iClk       (iClk),
    .iRst_n     (iRst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_tc       (w_tc)
  );

  // Next-state, timer control and next values of the registered outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_frame_nxt = r_frame;
    w_tmr_load  = 1'b0;
    w_tmr_val   = HOLD_LD;
    w_done_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_frame_nxt = bus.iData;
          w_ch_nxt    = '0;
          w_state_nxt = ST_SLOT;
          w_tmr_load  = 1'b1;
        end
      end
      ST_SLOT: begin
        if (w_tc) begin
          if (r_ch == LAST_CH) begin
            w_done_nxt = 1'b1;
            if (GAP == 0) begin
              w_state_nxt = ST_IDLE;
            end else begin
              w_state_nxt = ST_GAP;
              w_tmr_load  = 1'b1;
              w_tmr_val   = GAP_LD;
            end
          end else begin
            w_ch_nxt   = r_ch + SEL_W'(1);
            w_tmr_load = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (w_tc) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Demux drive is forced quiet outside SLOT so no stray bit reaches a channel.
    w_ready_nxt  = (w_state_nxt == ST_IDLE);
    w_strobe_nxt = (w_state_nxt == ST_SLOT);
    w_sel_nxt    = w_strobe_nxt ? w_ch_nxt : '0;
    w_c_nxt      = w_strobe_nxt & w_frame_nxt[w_ch_nxt];
  end

  // Control state and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_state  <= ST_IDLE;
      r_ch     <= '0;
      r_ready  <= 1'b1;
      r_c      <= 1'b0;
      r_sel    <= '0;
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ch     <= w_ch_nxt;
      r_ready  <= w_ready_nxt;
      r_c      <= w_c_nxt;
      r_sel    <= w_sel_nxt;
      r_strobe <= w_strobe_nxt;
      r_done   <= w_done_nxt;
      if (w_done_nxt) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Frame payload register; only read while a frame is being sequenced.
  always_ff @(posedge iClk) begin
    r_frame <= w_frame_nxt;
  end

  assign bus.oReady     = r_ready;
  assign bus.oC         = r_c;
  assign bus.oS0        = r_sel[0];
  assign bus.oS1        = r_sel[1];
  assign bus.oStrobe    = r_strobe;
  assign bus.oFrameDone = r_done;
  assign bus.oFrameCnt  = r_cnt;

endmodule
